ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, the number of clk cycles without a PS/2 falling edge that aborts a frame.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-005 The block SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 The block SHALL have port ps2_key_data  output  8  last correctly received scan byte.
REQ-007 The block SHALL have port ps2_key_en  output  1  one-cycle strobe marking a new valid ps2_key_data.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.
REQ-009 The block SHALL have port rx_busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 A PS/2 falling edge SHALL be detected as: synchronized ps2_clk = 0 while its previous-cycle value = 1.
- All data sampling happens only on detected falling edges.
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-013 IDLE: a falling edge with data = 0 (start bit) SHALL go to DATA with the bit counter cleared; a falling edge with data = 1 SHALL be ignored.
REQ-014 DATA: each falling edge SHALL shift in one data bit, LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-015 PARITY: the next falling edge SHALL capture the parity bit and go to STOP.
REQ-016 STOP: the next falling edge SHALL return the FSM to IDLE and evaluate the frame.
- Frame is good when stop bit = 1 and the 8 data bits plus parity contain an odd number of ones.
- Good frame: ps2_key_data <= byte and ps2_key_en = 1 for exactly one cycle.
- Bad frame: frame_err = 1 for exactly one cycle; ps2_key_en stays 0; ps2_key_data is unchanged.
REQ-017 ps2_key_en and frame_err SHALL be registered and SHALL never be high in the same cycle.
REQ-018 ps2_key_en SHALL assert on the clk cycle following the falling-edge detection of the stop bit.
- Total latency from the stop-bit pin falling edge to ps2_key_en is 3 to 4 clk cycles.
REQ-019 ps2_key_data SHALL hold its value until the next good frame.
REQ-020 Timeout counter behaviour:
- Cleared on every detected falling edge and in IDLE.
- Increments each cycle in any non-IDLE state.
- On reaching TIMEOUT_CYCLES: FSM to IDLE, one-cycle frame_err, partial byte discarded.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it SHALL saturate, never wrap.
REQ-021 Back-to-back frames with no idle gap SHALL each be decoded; the start bit of frame N+1 is accepted on the first falling edge after the STOP edge of frame N.
REQ-022 rx_busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-023 While reset = 1 at a clk edge, the block SHALL enter this state:
- FSM = IDLE; bit counter and timeout counter = 0.
- ps2_key_data = 8'h00; ps2_key_en = 0; frame_err = 0; rx_busy = 0.
- Synchronizer and edge-history flops = 1 (line idle), so no false edge is detected after release.
REQ-024 Reset SHALL take priority over every other event, including mid-frame and on the same cycle as a stop-bit edge; no strobe is issued for the interrupted frame.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (PS/2 bit period 20 clk cycles, TIMEOUT_CYCLES = 200):
- Frame 0x1C, parity 0, stop 1 -> exactly one ps2_key_en pulse with ps2_key_data = 8'h1C, 3-4 cycles after the stop edge; frame_err stays 0.
- Frames 0xF0 (parity 1) then 0xBB (parity 1), back-to-back -> two ps2_key_en pulses carrying 8'hF0 then 8'hBB, in order.
- Frame 0xF0 with parity 0 -> one frame_err pulse, no ps2_key_en, ps2_key_data keeps its previous value; same response for 0x1C sent with stop = 0.
- Start bit plus 4 data bits, then the line held idle for 250 cycles -> frame_err pulses once about 200 cycles after the last edge, rx_busy falls; a following good frame 0xE0 (parity 0) decodes as 8'hE0.
- reset pulsed after the 5th data bit of a frame -> all outputs at reset values, no strobe; the next full frame 0x1C decodes correctly.
- A single ps2_clk falling edge with ps2_data = 1 in IDLE -> no state change, no strobes.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. It synchronizes the raw lines, samples data on
// falling clock edges, checks parity and stop bit, and aborts stalled frames.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | capturing the stop bit, then the frame is evaluated
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_en,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic             clk_s1, clk_s2, clk_prev;
  logic             data_s1, data_s2;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity_bit;
  logic [CNT_W-1:0] to_cnt;
  logic             fall;

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clk_s1       <= 1'b1;
      clk_s2       <= 1'b1;
      clk_prev     <= 1'b1;
      data_s1      <= 1'b1;
      data_s2      <= 1'b1;
      bit_cnt      <= '0;
      shreg        <= '0;
      parity_bit   <= 1'b0;
      to_cnt       <= '0;
      ps2_key_data <= 8'h00;
      ps2_key_en   <= 1'b0;
      frame_err    <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      data_s1    <= ps2_data;
      data_s2    <= data_s1;
      ps2_key_en <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !data_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
          rx_busy <= 1'b1;
        end
      end else if (to_cnt == TO_MAX) begin
        // Stalled frame: drop whatever was collected so far.
        state     <= IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
        rx_busy   <= 1'b0;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s2;
            state      <= STOP;
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (data_s2 && (^{shreg, parity_bit})) begin
              ps2_key_data <= shreg;
              ps2_key_en   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good, bad-parity, bad-stop, back-to-back,
// timeout, mid-frame reset and spurious-edge frames with hand-computed results.
module tb_ps2_rx;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_key_data;
  logic       ps2_key_en;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int en_cyc = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;
  int overlap = 0;
  logic [7:0] key_q[$];

  ps2_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .ps2_key_data (ps2_key_data),
    .ps2_key_en   (ps2_key_en),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_key_en) begin
      en_cnt++;
      en_cyc = cyc;
      key_q.push_back(ps2_key_data);
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ps2_key_en && frame_err) overlap = 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 20-cycle PS/2 bit per iteration; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(5);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(10);
      ps2_clk = 1'b1;
      wait_cyc(5);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 11);
  endtask

  task automatic pop_key(input string tag, input logic [7:0] exp);
    logic [7:0] k;
    k = 8'hxx;
    if (key_q.size() > 0) k = key_q.pop_front();
    check_val(tag, {24'd0, k}, {24'd0, exp});
  endtask

  initial begin
    int lat;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check_val("rst_key_data", {24'd0, ps2_key_data}, 32'h00);
    check_val("rst_key_en", {31'd0, ps2_key_en}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_busy", {31'd0, rx_busy}, 32'd0);

    // Good frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    check_val("f1c_en_cnt", en_cnt, 1);
    pop_key("f1c_key", 8'h1C);
    check_val("f1c_key_data", {24'd0, ps2_key_data}, 32'h1C);
    check_val("f1c_err_cnt", err_cnt, 0);
    lat = en_cyc - last_fall_cyc;
    check_val("f1c_latency_3to4", {31'd0, (lat >= 3 && lat <= 4)}, 32'd1);

    // Back-to-back 0xF0, 0xBB
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'hBB, 1'b1, 1'b1);
    wait_cyc(10);
    check_val("b2b_en_cnt", en_cnt, 3);
    pop_key("b2b_first", 8'hF0);
    pop_key("b2b_second", 8'hBB);

    // Bad parity, then bad stop
    send_frame(8'hF0, 1'b0, 1'b1);
    wait_cyc(10);
    check_val("par_err_cnt", err_cnt, 1);
    check_val("par_en_cnt", en_cnt, 3);
    check_val("par_key_hold", {24'd0, ps2_key_data}, 32'hBB);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cyc(10);
    check_val("stop_err_cnt", err_cnt, 2);
    check_val("stop_en_cnt", en_cnt, 3);
    check_val("stop_key_hold", {24'd0, ps2_key_data}, 32'hBB);

    // Timeout after start + 4 data bits
    send_bits({2'b11, 8'hA5, 1'b0}, 5);
    wait_cyc(20);
    check_val("to_busy_mid", {31'd0, rx_busy}, 32'd1);
    wait_cyc(230);
    check_val("to_err_cnt", err_cnt, 3);
    lat = err_cyc - last_fall_cyc;
    check_val("to_err_timing", {31'd0, (lat >= 200 && lat <= 206)}, 32'd1);
    check_val("to_busy_after", {31'd0, rx_busy}, 32'd0);
    check_val("to_en_cnt", en_cnt, 3);
    send_frame(8'hE0, 1'b0, 1'b1);
    wait_cyc(10);
    check_val("e0_en_cnt", en_cnt, 4);
    pop_key("e0_key", 8'hE0);

    // Reset after the 5th data bit
    send_bits({2'b11, 8'h5A, 1'b0}, 6);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    check_val("mr_key_data", {24'd0, ps2_key_data}, 32'h00);
    check_val("mr_busy", {31'd0, rx_busy}, 32'd0);
    check_val("mr_key_en", {31'd0, ps2_key_en}, 32'd0);
    check_val("mr_frame_err", {31'd0, frame_err}, 32'd0);
    wait_cyc(250);
    check_val("mr_no_strobe", en_cnt + err_cnt, 7);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    check_val("mr_en_cnt", en_cnt, 5);
    pop_key("mr_key", 8'h1C);

    // Lone falling edge with data high in IDLE
    ps2_data = 1'b1;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(6);
    check_val("spur_busy_low", {31'd0, rx_busy}, 32'd0);
    wait_cyc(4);
    ps2_clk = 1'b1;
    wait_cyc(10);
    check_val("spur_busy", {31'd0, rx_busy}, 32'd0);
    check_val("spur_counts", en_cnt * 16 + err_cnt, 5 * 16 + 3);
    check_val("spur_key_hold", {24'd0, ps2_key_data}, 32'h1C);

    check_val("en_err_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
